// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: memory geometry, FSM
// encoding, active-low RAM control levels and count helpers.
package program_loader_pkg;

  localparam int ADDRESS_WIDTH = 11;
  localparam int DATA_WIDTH    = 32;
  localparam int CNT_WIDTH     = ADDRESS_WIDTH + 1;
  localparam int RUN_WIDTH     = 32;

  localparam logic MEM_ON  = 1'b0;
  localparam logic MEM_OFF = 1'b1;

  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(1 << ADDRESS_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_IM   = 3'd1,
    ST_LOAD_DM   = 3'd2,
    ST_RUN       = 3'd3,
    ST_DUMP_RD   = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] clamp_words(input logic [CNT_WIDTH-1:0] words);
    return (words > MAX_WORDS) ? MAX_WORDS : words;
  endfunction

  // Walks forward from 'from' past every phase whose count is zero.
  function automatic state_t skip_empty(input state_t from, input logic im_nz,
                                        input logic dm_nz, input logic run_nz,
                                        input logic dump_nz);
    state_t s;
    s = from;
    if (s == ST_LOAD_IM && !im_nz)   s = ST_LOAD_DM;
    if (s == ST_LOAD_DM && !dm_nz)   s = ST_RUN;
    if (s == ST_RUN     && !run_nz)  s = ST_DUMP_RD;
    if (s == ST_DUMP_RD && !dump_nz) s = ST_DONE;
    return s;
  endfunction

endpackage

// File: rtl/program_loader_word_counter.sv
// Clearable word-index up-counter with a last-word compare against a limit;
// shared by the IM load, DM load and DM dump phases.
module loader_word_counter
  import program_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     inc,
  input  logic [CNT_WIDTH-1:0]     limit,
  output logic [ADDRESS_WIDTH-1:0] index,
  output logic                     last
);

  logic [CNT_WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // Full-width compare so a limit of 2048 ends at index 2047 without wrapping.
  assign last  = (count + CNT_WIDTH'(1)) == limit;
  assign index = count[ADDRESS_WIDTH-1:0];

endmodule

// File: rtl/program_loader.sv
// Host-side loader: streams a program into IM and an image into DM, lets the
// core run for a fixed number of cycles, then streams DM words back out.
module program_loader
  import program_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_start,
  input  logic [CNT_WIDTH-1:0]     cmd_im_words,
  input  logic [CNT_WIDTH-1:0]     cmd_dm_words,
  input  logic [RUN_WIDTH-1:0]     cmd_run_cycles,
  input  logic [CNT_WIDTH-1:0]     cmd_dump_words,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  input  logic [DATA_WIDTH-1:0]    dm_q,
  output logic                     loading,
  output logic                     im_cen_load,
  output logic                     im_wen_load,
  output logic                     im_oen_load,
  output logic [ADDRESS_WIDTH-1:0] im_addr_load,
  output logic [DATA_WIDTH-1:0]    im_datain_load,
  output logic                     dm_cen_load,
  output logic                     dm_wen_load,
  output logic                     dm_oen_load,
  output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
  output logic [DATA_WIDTH-1:0]    dm_datain_load,
  output logic                     busy,
  output logic                     done
);

  state_t                   state, next_state;
  logic [CNT_WIDTH-1:0]     im_words_q, dm_words_q, dump_words_q, word_limit;
  logic [CNT_WIDTH-1:0]     start_im, start_dm, start_dump;
  logic [RUN_WIDTH-1:0]     run_left;
  logic [DATA_WIDTH-1:0]    out_data_q;
  logic                     out_valid_q;
  logic [ADDRESS_WIDTH-1:0] word_index;
  logic                     word_last, in_load, load_write, dump_hs, phase_step;

  assign start_im   = clamp_words(cmd_im_words);
  assign start_dm   = clamp_words(cmd_dm_words);
  assign start_dump = clamp_words(cmd_dump_words);

  assign in_load    = (state == ST_LOAD_IM) || (state == ST_LOAD_DM);
  assign load_write = in_load && in_valid;
  assign dump_hs    = (state == ST_DUMP_WAIT) && out_valid_q && out_ready;
  assign phase_step = load_write || dump_hs;

  always_comb begin
    case (state)
      ST_LOAD_IM: word_limit = im_words_q;
      ST_LOAD_DM: word_limit = dm_words_q;
      default:    word_limit = dump_words_q;
    endcase
  end

  loader_word_counter u_word_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (phase_step && word_last),
    .inc   (phase_step && !word_last),
    .limit (word_limit),
    .index (word_index),
    .last  (word_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:
        if (cmd_start)
          next_state = skip_empty(ST_LOAD_IM, |start_im, |start_dm, |cmd_run_cycles, |start_dump);
      ST_LOAD_IM:
        if (load_write && word_last)
          next_state = skip_empty(ST_LOAD_DM, 1'b0, |dm_words_q, |run_left, |dump_words_q);
      ST_LOAD_DM:
        if (load_write && word_last)
          next_state = skip_empty(ST_RUN, 1'b0, 1'b0, |run_left, |dump_words_q);
      ST_RUN:
        if (run_left <= RUN_WIDTH'(1))
          next_state = skip_empty(ST_DUMP_RD, 1'b0, 1'b0, 1'b0, |dump_words_q);
      ST_DUMP_RD:   next_state = ST_DUMP_WAIT;
      ST_DUMP_WAIT:
        if (dump_hs) next_state = word_last ? ST_DONE : ST_DUMP_RD;
      ST_DONE:      next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // The first DUMP_WAIT cycle sees the read data; capture it and hold it
  // until the consumer accepts, so a stalled sink never re-reads the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_words_q   <= '0;
      dm_words_q   <= '0;
      dump_words_q <= '0;
      run_left     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && cmd_start) begin
        im_words_q   <= start_im;
        dm_words_q   <= start_dm;
        dump_words_q <= start_dump;
        run_left     <= cmd_run_cycles;
      end else if (state == ST_RUN && run_left != '0) begin
        run_left <= run_left - RUN_WIDTH'(1);
      end

      if (state == ST_DUMP_WAIT && !out_valid_q) begin
        out_data_q  <= dm_q;
        out_valid_q <= 1'b1;
      end else if (dump_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    loading        = 1'b0;
    in_ready       = 1'b0;
    im_cen_load    = MEM_OFF;
    im_wen_load    = MEM_OFF;
    im_oen_load    = MEM_OFF;
    im_addr_load   = '0;
    im_datain_load = '0;
    dm_cen_load    = MEM_OFF;
    dm_wen_load    = MEM_OFF;
    dm_oen_load    = MEM_OFF;
    dm_addr_load   = '0;
    dm_datain_load = '0;
    case (state)
      ST_LOAD_IM: begin
        loading        = 1'b1;
        in_ready       = 1'b1;
        im_cen_load    = in_valid ? MEM_ON : MEM_OFF;
        im_wen_load    = in_valid ? MEM_ON : MEM_OFF;
        im_addr_load   = word_index;
        im_datain_load = in_data;
      end
      ST_LOAD_DM: begin
        loading        = 1'b1;
        in_ready       = 1'b1;
        dm_cen_load    = in_valid ? MEM_ON : MEM_OFF;
        dm_wen_load    = in_valid ? MEM_ON : MEM_OFF;
        dm_addr_load   = word_index;
        dm_datain_load = in_data;
      end
      ST_DUMP_RD: begin
        loading      = 1'b1;
        dm_cen_load  = MEM_ON;
        dm_oen_load  = MEM_ON;
        dm_addr_load = word_index;
      end
      // Output stays enabled while waiting so Q is still driven when captured.
      ST_DUMP_WAIT: begin
        loading      = 1'b1;
        dm_oen_load  = MEM_ON;
        dm_addr_load = word_index;
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: behavioural IM/DM models, a table of
// load/run/dump commands, and hand-written reset-abort sequences.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start;
  logic [11:0] cmd_im_words, cmd_dm_words, cmd_dump_words;
  logic [31:0] cmd_run_cycles;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data, dm_q;
  logic        loading, busy, done;
  logic        im_cen_load, im_wen_load, im_oen_load;
  logic        dm_cen_load, dm_wen_load, dm_oen_load;
  logic [10:0] im_addr_load, dm_addr_load;
  logic [31:0] im_datain_load, dm_datain_load;

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
    .cmd_im_words(cmd_im_words), .cmd_dm_words(cmd_dm_words),
    .cmd_run_cycles(cmd_run_cycles), .cmd_dump_words(cmd_dump_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .dm_q(dm_q), .loading(loading),
    .im_cen_load(im_cen_load), .im_wen_load(im_wen_load), .im_oen_load(im_oen_load),
    .im_addr_load(im_addr_load), .im_datain_load(im_datain_load),
    .dm_cen_load(dm_cen_load), .dm_wen_load(dm_wen_load), .dm_oen_load(dm_oen_load),
    .dm_addr_load(dm_addr_load), .dm_datain_load(dm_datain_load),
    .busy(busy), .done(done)
  );

  // Behavioural RAM2Kx32 models with one-cycle read latency.
  logic [31:0] im_mem [2048];
  logic [31:0] dm_mem [2048];
  int im_wr_cnt = 0, im_rd_cnt = 0, dm_wr_cnt = 0, dm_rd_cnt = 0;
  int im_log[$];
  int dm_log[$];

  always @(posedge clk) begin
    if (!im_cen_load && !im_wen_load) begin
      im_mem[im_addr_load] <= im_datain_load;
      im_wr_cnt <= im_wr_cnt + 1;
      im_log.push_back(int'(im_addr_load));
    end
    if (!im_cen_load && im_wen_load) im_rd_cnt <= im_rd_cnt + 1;
    if (!dm_cen_load && !dm_wen_load) begin
      dm_mem[dm_addr_load] <= dm_datain_load;
      dm_wr_cnt <= dm_wr_cnt + 1;
      dm_log.push_back(int'(dm_addr_load));
    end
    if (!dm_cen_load && dm_wen_load) begin
      dm_q      <= dm_mem[dm_addr_load];
      dm_rd_cnt <= dm_rd_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] im, dm;
    logic [31:0] run;
    logic [11:0] dump;
    bit          toggle;   // in_valid alternates 1,0,1,0
    bit          stall;    // hold out_ready low 5 cycles on the first dump word
    int          poke;     // cycle index at which to pulse cmd_start, -1 = never
    int          exp_im, exp_dm, exp_run, exp_dump;
    int          exp_busy; // 0 = timing not checked
  } vec_t;

  localparam int NVEC   = 6;
  localparam int BUDGET = 5000;
  vec_t vecs [NVEC];

  task automatic run_cmd(input vec_t v, input int row);
    logic [31:0] base, held;
    logic [31:0] got[$];
    int s_im, s_dm, w_im0, w_dm0, r_im0, r_dm0;
    int seq, run_c, busy_c, done_c, viol, stall_left, e;
    bit finished, was_stalled;
    string tag;
    tag = $sformatf("row%0d", row);
    base = 32'(row + 1) << 28;
    s_im = im_log.size();   s_dm = dm_log.size();
    w_im0 = im_wr_cnt;      w_dm0 = dm_wr_cnt;
    r_im0 = im_rd_cnt;      r_dm0 = dm_rd_cnt;
    seq = 0; run_c = 0; busy_c = 0; done_c = 0; viol = 0;
    stall_left = v.stall ? 5 : 0;
    finished = 0; was_stalled = 0; held = '0;

    @(negedge clk);
    cmd_im_words = v.im; cmd_dm_words = v.dm;
    cmd_run_cycles = v.run; cmd_dump_words = v.dump;
    cmd_start = 1'b1;
    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      @(negedge clk);
      if (busy) busy_c++;
      if (busy && !loading && !done) run_c++;
      if (done) done_c++;
      if (v.poke == cyc) begin
        cmd_start = 1'b1; cmd_im_words = 12'd5; cmd_run_cycles = 32'd3;
      end else begin
        cmd_start = 1'b0;
      end
      in_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = base + 32'(seq);
      if (was_stalled && (out_valid !== 1'b1 || out_data !== held || dm_cen_load !== 1'b1)) viol++;
      was_stalled = 0;
      if (stall_left > 0 && out_valid) begin
        out_ready = 1'b0; stall_left--; held = out_data; was_stalled = 1;
        if (dm_cen_load !== 1'b1) viol++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (in_ready && !in_valid && (!im_cen_load || !dm_cen_load)) viol++;
      if (in_valid && in_ready) seq++;
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) finished = 1;
    end
    if (!finished) begin
      n_chk++; n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, BUDGET);
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_c++;
    end

    check({tag, " im_writes"}, 32'(im_wr_cnt - w_im0), 32'(v.exp_im));
    check({tag, " dm_writes"}, 32'(dm_wr_cnt - w_dm0), 32'(v.exp_dm));
    check({tag, " dm_reads"},  32'(dm_rd_cnt - r_dm0), 32'(v.exp_dump));
    check({tag, " im_reads"},  32'(im_rd_cnt - r_im0), 32'd0);
    check({tag, " run_cycles"}, 32'(run_c), 32'(v.exp_run));
    check({tag, " done_pulses"}, 32'(done_c), 32'd1);
    check({tag, " dump_count"}, 32'(got.size()), 32'(v.exp_dump));
    check({tag, " protocol"}, 32'(viol), 32'd0);
    if (v.exp_busy != 0) check({tag, " busy_cycles"}, 32'(busy_c), 32'(v.exp_busy));
    if (v.stall) check({tag, " stall_seen"}, 32'(stall_left), 32'd0);

    e = 0;
    for (int i = 0; i < v.exp_im; i++) if (im_mem[i] !== base + 32'(i)) e++;
    for (int i = 0; i < v.exp_dm; i++) if (dm_mem[i] !== base + 32'(v.exp_im + i)) e++;
    check({tag, " mem_data"}, 32'(e), 32'd0);
    e = 0;
    for (int i = s_im; i < im_log.size(); i++) if (im_log[i] != i - s_im) e++;
    for (int i = s_dm; i < dm_log.size(); i++) if (dm_log[i] != i - s_dm) e++;
    check({tag, " addr_seq"}, 32'(e), 32'd0);
    e = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== base + 32'(v.exp_im + i)) e++;
    check({tag, " dump_data"}, 32'(e), 32'd0);
    if (im_log.size() > s_im) check({tag, " im_last_addr"}, 32'(im_log[$]), 32'(v.exp_im - 1));
  endtask

  initial begin
    vecs[0] = '{12'd4,    12'd2, 32'd10, 12'd2, 1'b0, 1'b0, -1, 4,    2, 10, 2, 23};
    vecs[1] = '{12'd0,    12'd0, 32'd0,  12'd0, 1'b0, 1'b0, -1, 0,    0, 0,  0, 1};
    vecs[2] = '{12'd2,    12'd4, 32'd3,  12'd3, 1'b1, 1'b0, -1, 2,    4, 3,  3, 0};
    vecs[3] = '{12'd1,    12'd3, 32'd0,  12'd1, 1'b0, 1'b1, -1, 1,    3, 0,  1, 13};
    vecs[4] = '{12'd3000, 12'd0, 32'd0,  12'd0, 1'b0, 1'b0, -1, 2048, 0, 0,  0, 2049};
    vecs[5] = '{12'd0,    12'd0, 32'd20, 12'd0, 1'b0, 1'b0, 5,  0,    0, 20, 0, 21};

    rst_n = 1'b0; cmd_start = 1'b0;
    cmd_im_words = '0; cmd_dm_words = '0; cmd_run_cycles = '0; cmd_dump_words = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset loading",  32'(loading), 32'd0);
    check("reset im_ctl",   32'({im_cen_load, im_wen_load, im_oen_load}), 32'd7);
    check("reset dm_ctl",   32'({dm_cen_load, dm_wen_load, dm_oen_load}), 32'd7);
    check("reset addr",     32'({im_addr_load, dm_addr_load}), 32'd0);
    check("reset flags",    32'({in_ready, out_valid, busy, done}), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < NVEC; r++) run_cmd(vecs[r], r);

    // Asynchronous reset in the middle of an IM load after three writes.
    begin
      int w0;
      w0 = im_wr_cnt;
      @(negedge clk);
      cmd_im_words = 12'd8; cmd_dm_words = 12'd0; cmd_run_cycles = 32'd0; cmd_dump_words = 12'd0;
      cmd_start = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        cmd_start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hC0DE_0000 + 32'(k);
      end
      #1;
      check("abort pre_cen", 32'(im_cen_load), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort im_ctl",  32'({im_cen_load, im_wen_load, im_oen_load}), 32'd7);
      check("abort dm_ctl",  32'({dm_cen_load, dm_wen_load, dm_oen_load}), 32'd7);
      check("abort loading", 32'(loading), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort busy",    32'(busy), 32'd0);
      check("abort writes",  32'(im_wr_cnt - w0), 32'd3);
      check("abort im0",     im_mem[0], 32'hC0DE_0000);
      check("abort im1",     im_mem[1], 32'hC0DE_0001);
      check("abort im2",     im_mem[2], 32'hC0DE_0002);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
